// File: rtl/uart_pkg.sv
// Shared definitions for the UART command assembler: FSM encoding, default widths
// and the frame parity helper.
package uart_pkg;

    localparam int DEF_N_DATA    = 8;
    localparam int DEF_NB_OPCODE = 6;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        COMPUTE = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    // Word is zero-extended by the caller; padding zeros do not change the XOR.
    function automatic logic f_parity_ok(input logic [31:0] word, input logic even_odd);
        return even_odd ? (^word == 1'b0) : (^word == 1'b1);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles without a clear and flags expiry
// at N_TIMEOUT-1; a clear in the expiry cycle suppresses the expiry.
module cmd_timeout_timer #(
    parameter int N_TIMEOUT  = 50000,
    parameter int NB_TIMEOUT = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    logic [NB_TIMEOUT-1:0] count;

    assign o_expired = i_enable && !i_clear && (count == NB_TIMEOUT'(N_TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear || !i_enable || o_expired) begin
            count <= '0;
        end else begin
            count <= count + NB_TIMEOUT'(1);
        end
    end

endmodule

// File: rtl/uart_rx_alu_if.sv
// Collects A, B and opcode bytes from uart_rx, drives the ALU, and hands the result to TX.
// Build macro UART_RX_PARITY_CHECK_EN enables frame parity checking and o_parity_err.
module uart_rx_alu_if
    import uart_pkg::*;
#(
    parameter int N_DATA          = DEF_N_DATA,
    parameter int PARITY_CHECK    = 1,
    parameter int EVEN_ODD_PARITY = 1,
    parameter int NB_OPCODE       = DEF_NB_OPCODE,
    parameter int N_TIMEOUT       = 50000,
    parameter int NB_TIMEOUT      = 16
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [N_DATA+PARITY_CHECK-1:0] i_rx_data,
    input  logic                           i_rx_done,
    input  logic [N_DATA-1:0]              i_alu_result,
    input  logic                           i_tx_done,
    output logic [N_DATA-1:0]              o_data_a,
    output logic [N_DATA-1:0]              o_data_b,
    output logic [NB_OPCODE-1:0]           o_opcode,
    output logic [N_DATA-1:0]              o_tx_data,
    output logic                           o_tx_start,
    output logic                           o_parity_err,
    output logic                           o_overrun
);

    state_t state;
    logic   parity_ok;
    logic   collecting;
    logic   in_wait;
    logic   accept;
    logic   expired;

`ifdef UART_RX_PARITY_CHECK_EN
    logic [31:0] rx_word;
    assign rx_word   = 32'(i_rx_data);
    assign parity_ok = (PARITY_CHECK == 0) || f_parity_ok(rx_word, EVEN_ODD_PARITY != 0);
`else
    logic unused_rx_parity;
    assign unused_rx_parity = ^i_rx_data;
    assign parity_ok        = 1'b1;
`endif

    // in_wait: states that take frames; collecting: states where the idle timer runs.
    assign collecting = (state == WAIT_B) || (state == WAIT_OP);
    assign in_wait    = collecting || (state == WAIT_A);
    assign accept     = i_rx_done && parity_ok && in_wait;

    cmd_timeout_timer #(
        .N_TIMEOUT  (N_TIMEOUT),
        .NB_TIMEOUT (NB_TIMEOUT)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_enable  (collecting),
        .i_clear   (accept),
        .o_expired (expired)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state      <= WAIT_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_opcode   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_overrun  <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (accept) begin
                        o_data_a <= i_rx_data[N_DATA-1:0];
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (accept) begin
                        o_data_b <= i_rx_data[N_DATA-1:0];
                        state    <= WAIT_OP;
                    end else if (expired) begin
                        state <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (accept) begin
                        o_opcode <= i_rx_data[NB_OPCODE-1:0];
                        state    <= COMPUTE;
                    end else if (expired) begin
                        state <= WAIT_A;
                    end
                end
                COMPUTE: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    o_overrun  <= i_rx_done;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    o_overrun <= i_rx_done;
                    if (i_tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= i_rx_done && !parity_ok && in_wait;
        end
    end
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_alu_if.sv
// Directed bench for uart_rx_alu_if with a queue-based command model checked every cycle.
module tb_uart_rx_alu_if;

    localparam int NT = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result, data_a, data_b, tx_data;
    logic [5:0] opcode;
    logic       tx_start, parity_err, overrun;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Environment ALU: A + B.
    assign alu_result = data_a + data_b;

    uart_rx_alu_if #(
        .N_DATA(8), .PARITY_CHECK(1), .EVEN_ODD_PARITY(1),
        .NB_OPCODE(6), .N_TIMEOUT(NT), .NB_TIMEOUT(16)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_result), .i_tx_done(tx_done),
        .o_data_a(data_a), .o_data_b(data_b), .o_opcode(opcode), .o_tx_data(tx_data),
        .o_tx_start(tx_start), .o_parity_err(parity_err), .o_overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Even-parity frame; good=0 flips the parity bit.
    function automatic logic [8:0] frame(input logic [7:0] b, input bit good);
        logic p;
        p = ($countones(b) % 2) == 1;
        return {good ? p : ~p, b};
    endfunction

    function automatic bit frame_bad(input logic [8:0] w);
`ifdef UART_RX_PARITY_CHECK_EN
        return ($countones(w) % 2) != 0;
`else
        return (w === 9'bx);
`endif
    endfunction

    // Model: bytes of the pending command sit in a queue; busy flags cover compute/TX.
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    bit         m_start, m_perr, m_ovr, m_compute, m_tx_busy, m_valid;
    logic [7:0] got[$];
    int         idle_cnt;

    always @(posedge clk) begin
        m_start = 0; m_perr = 0; m_ovr = 0;
        if (!rst_n) begin
            got.delete(); idle_cnt = 0; m_compute = 0; m_tx_busy = 0;
            m_a = '0; m_b = '0; m_op = '0; m_tx = '0; m_valid = 1;
        end else if (m_compute || m_tx_busy) begin
            m_ovr = rx_done;
            if (m_compute) begin
                m_tx = m_a + m_b; m_start = 1; m_compute = 0; m_tx_busy = 1;
            end else if (tx_done) begin
                m_tx_busy = 0;
            end
        end else if (rx_done && !frame_bad(rx_data)) begin
            got.push_back(rx_data[7:0]);
            idle_cnt = 0;
            case (got.size())
                1: m_a = got[0];
                2: m_b = got[1];
                default: begin
                    m_op = got[2][5:0];
                    got.delete();
                    m_compute = 1;
                end
            endcase
        end else begin
            m_perr = rx_done;
            if (got.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == NT) begin
                    got.delete(); idle_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_a", data_a, m_a);
            chk("cyc_b", data_b, m_b);
            chk("cyc_op", opcode, m_op);
            chk("cyc_tx_data", tx_data, m_tx);
            chk("cyc_tx_start", tx_start, m_start);
            chk("cyc_parity_err", parity_err, m_perr);
            chk("cyc_overrun", overrun, m_ovr);
        end
    end

    task automatic send(input logic [7:0] b, input bit good = 1);
        rx_data = frame(b, good); rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic tx_ack();
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Call right after the opcode frame: start is low one cycle, then high one cycle.
    task automatic expect_tx(input logic [7:0] v);
        @(negedge clk);
        chk("start_not_early", tx_start, 1'b0);
        @(negedge clk);
        chk("start_pulse", tx_start, 1'b1);
        chk("tx_data", tx_data, v);
        chk("model_tx", m_tx, v);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        @(negedge clk);
        chk("rst_a", data_a, 0);  chk("rst_b", data_b, 0);  chk("rst_op", opcode, 0);
        chk("rst_tx", tx_data, 0); chk("rst_start", tx_start, 0);
        chk("rst_perr", parity_err, 0); chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic command
        send(8'h05); send(8'h03); send(8'h20);
        expect_tx(8'h08);
        chk("t1_a", data_a, 8'h05); chk("t1_b", data_b, 8'h03); chk("t1_op", opcode, 6'h20);
        idle(1);
        tx_ack();

        // 2: bad parity frame
        do_reset();
        send(8'h05, 0);
        @(negedge clk);
`ifdef UART_RX_PARITY_CHECK_EN
        chk("t2_perr", parity_err, 1'b1);
        chk("t2_a", data_a, 8'h00);
`else
        chk("t2_perr", parity_err, 1'b0);
        chk("t2_a", data_a, 8'h05);
`endif
        @(posedge clk); #1;
        do_reset();

        // 3: timeout after A, then a full command
        send(8'h11); idle(NT);
        send(8'h01); send(8'h02); send(8'h2A);
        expect_tx(8'h03);
        tx_ack();

        // 3b: byte arriving in the expiry cycle is accepted
        send(8'h11); idle(NT - 1);
        send(8'h22); send(8'h01);
        expect_tx(8'h33);
        tx_ack();

        // 4: overrun while waiting on TX
        send(8'h40); send(8'h02); send(8'h03);
        expect_tx(8'h42);
        send(8'h7F);
        @(negedge clk);
        chk("t4_overrun", overrun, 1'b1);
        @(posedge clk); #1;
        tx_ack();
        send(8'h10); send(8'h20); send(8'h05);
        expect_tx(8'h30);
        tx_ack();

        // 5: reset in WAIT_OP
        send(8'h33); send(8'h44);
        do_reset();
        @(negedge clk);
        chk("t5_a", data_a, 0); chk("t5_b", data_b, 0); chk("t5_op", opcode, 0);
        chk("t5_tx", tx_data, 0); chk("t5_start", tx_start, 0);
        @(posedge clk); #1;
        send(8'h09); send(8'h04); send(8'h01);
        expect_tx(8'h0D);
        tx_ack();

        // 6: back-to-back frames with 8-bit wrap
        send(8'hFF); send(8'h01); send(8'h3F);
        expect_tx(8'h00);
        chk("t6_op", opcode, 6'h3F);
        tx_ack();

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
